// File: rtl/rsa_xcel_pkg.sv
// Shared definitions for the RSA accelerator client: xcel message formats,
// accelerator register map and the transaction step count.
package rsa_xcel_pkg;

  typedef struct packed {
    logic [7:0]  opaque;
    logic        msg_type;
    logic [4:0]  addr;
    logic [31:0] data;
  } xcel_req_t;

  typedef struct packed {
    logic [7:0]  opaque;
    logic        msg_type;
    logic [31:0] data;
  } xcel_resp_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  localparam logic       XCEL_TYPE_READ  = 1'b0;
  localparam logic       XCEL_TYPE_WRITE = 1'b1;

  localparam logic [4:0] RSA_XR_GO   = 5'd0;
  localparam logic [4:0] RSA_XR_BASE = 5'd1;
  localparam logic [4:0] RSA_XR_EXP  = 5'd2;
  localparam logic [4:0] RSA_XR_MOD  = 5'd3;

  localparam logic [2:0] RSA_NUM_STEPS = 3'd5;

  // Simulation-only trace of one cycle; requests and responses appear only on fire.
  function automatic string line_trace(state_t st, logic [2:0] step,
                                       xcel_req_t req, logic req_fire,
                                       xcel_resp_t resp, logic resp_fire);
    string rq;
    string rs;
    rq = "";
    rs = "";
    if (req_fire)
      rq = $sformatf("%s:%0h:%0h:%0h", (req.msg_type == XCEL_TYPE_WRITE) ? "wr" : "rd",
                     req.opaque, req.addr, req.data);
    if (resp_fire)
      rs = $sformatf("%s:%0h:%0h", (resp.msg_type == XCEL_TYPE_WRITE) ? "wr" : "rd",
                     resp.opaque, resp.data);
    return $sformatf("%-4s s%0d |%-20s|%-14s", st.name(), step, rq, rs);
  endfunction

endpackage

// File: rtl/rsa_xcel_client.sv
// Initiator-side driver for the RSA modexp accelerator: writes base, exponent,
// modulus and go, then reads the result back and returns it on the output stream.
module rsa_xcel_client
  import rsa_xcel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic [95:0] istream_msg,
  input  logic        istream_val,
  output logic        istream_rdy,

  output logic [31:0] ostream_msg,
  output logic        ostream_val,
  input  logic        ostream_rdy,

  output xcel_req_t   xcel_reqstream_msg,
  output logic        xcel_reqstream_val,
  input  logic        xcel_reqstream_rdy,

  input  xcel_resp_t  xcel_respstream_msg,
  input  logic        xcel_respstream_val,
  output logic        xcel_respstream_rdy,

  output logic        error
);

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] base_q, base_d;
  logic [31:0] exp_q, exp_d;
  logic [31:0] mod_q, mod_d;
  logic [31:0] result_q, result_d;
  logic        error_q, error_d;
  xcel_req_t   req_msg;
  logic        resp_mismatch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      base_q   <= 32'd0;
      exp_q    <= 32'd0;
      mod_q    <= 32'd0;
      result_q <= 32'd0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  // The request is a pure function of the step and latched operands, so it
  // stays stable for as long as the accelerator stalls it.
  always_comb begin
    req_msg.opaque = {5'd0, step_q};
    case (step_q)
      3'd0: begin
        req_msg.msg_type = XCEL_TYPE_WRITE;
        req_msg.addr     = RSA_XR_BASE;
        req_msg.data     = base_q;
      end
      3'd1: begin
        req_msg.msg_type = XCEL_TYPE_WRITE;
        req_msg.addr     = RSA_XR_EXP;
        req_msg.data     = exp_q;
      end
      3'd2: begin
        req_msg.msg_type = XCEL_TYPE_WRITE;
        req_msg.addr     = RSA_XR_MOD;
        req_msg.data     = mod_q;
      end
      3'd3: begin
        req_msg.msg_type = XCEL_TYPE_WRITE;
        req_msg.addr     = RSA_XR_GO;
        req_msg.data     = 32'd1;
      end
      default: begin
        req_msg.msg_type = XCEL_TYPE_READ;
        req_msg.addr     = RSA_XR_GO;
        req_msg.data     = 32'd0;
      end
    endcase
  end

  assign resp_mismatch = (xcel_respstream_msg.opaque != req_msg.opaque) ||
                         (xcel_respstream_msg.msg_type != req_msg.msg_type);

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      IDLE: begin
        if (istream_val) begin
          base_d  = istream_msg[95:64];
          exp_d   = istream_msg[63:32];
          mod_d   = istream_msg[31:0];
          step_d  = 3'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (xcel_reqstream_rdy) state_d = RESP;
      end
      RESP: begin
        if (xcel_respstream_val) begin
          if (resp_mismatch) error_d = 1'b1;
          if (step_q == RSA_NUM_STEPS - 3'd1) begin
            result_d = xcel_respstream_msg.data;
            state_d  = DONE;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = REQ;
          end
        end
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign istream_rdy         = (state_q == IDLE);
  assign xcel_reqstream_val  = (state_q == REQ);
  assign xcel_respstream_rdy = (state_q == RESP);
  assign ostream_val         = (state_q == DONE);
  assign xcel_reqstream_msg  = req_msg;
  assign ostream_msg         = result_q;
  assign error               = error_q;

endmodule
